// File: rtl/comparador_serie_i_d_pkg.sv
// Shared types for the bit-serial magnitude comparator: FSM states,
// result encoding and the width of the examined-bit counter.
package comparador_serie_i_d_pkg;

    typedef enum logic [1:0] {
        REPOSO  = 2'd0,
        COMPARA = 2'd1,
        FIN     = 2'd2
    } estado_t;

    typedef enum logic [1:0] {
        RES_NINGUNO = 2'd0,
        RES_MENOR   = 2'd1,
        RES_IGUAL   = 2'd2,
        RES_MAYOR   = 2'd3
    } resultado_t;

    // Bits needed to count from 0 up to n inclusive.
    function automatic int ancho_ciclos(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/comparador_serie_i_d_celda.sv
// One-bit decision cell: tells whether a differing bit makes A smaller or larger.
// On the sign bit of a two's-complement word the sense is inverted.
module celda_bit_i_d (
    input  logic a,
    input  logic b,
    input  logic msb_con_signo,
    output logic menor,
    output logic mayor
);

    always_comb begin
        if (msb_con_signo) begin
            menor = a & ~b;
            mayor = ~a & b;
        end else begin
            menor = ~a & b;
            mayor = a & ~b;
        end
    end

endmodule

// File: rtl/comparador_serie_i_d.sv
// Bit-serial magnitude comparator: scans MSB to LSB one bit per clock,
// optionally stopping at the first differing bit, with a start/listo handshake.
module comparador_serie_i_d
    import comparador_serie_i_d_pkg::*;
#(
    parameter int N          = 8,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic                     signo,
    input  logic [N-1:0]             palabraA,
    input  logic [N-1:0]             palabraB,
    output logic                     ocupado,
    output logic                     listo,
    output logic                     a_menor_b,
    output logic                     a_igual_b,
    output logic                     a_mayor_b,
    output logic [$clog2(N+1)-1:0]   ciclos
);

    localparam int CW = ancho_ciclos(N);
    localparam int IW = $clog2(N);

    estado_t    estado, estado_sig;
    logic [N-1:0]  a_q, b_q;
    logic          signo_q;
    logic [IW-1:0] idx;
    logic [CW-1:0] cnt;
    logic          dec_valida;
    resultado_t    dec_q;
    resultado_t    res_q;
    logic [CW-1:0] ciclos_q;

    logic       msb_con_signo, menor, mayor, difiere, ultimo;
    resultado_t res_celda, res_fin;

    // The single cell is time-multiplexed over idx.
    assign msb_con_signo = signo_q & (idx == IW'(N - 1));

    celda_bit_i_d u_celda (
        .a             (a_q[idx]),
        .b             (b_q[idx]),
        .msb_con_signo (msb_con_signo),
        .menor         (menor),
        .mayor         (mayor)
    );

    assign difiere   = menor | mayor;
    assign ultimo    = (idx == '0);
    assign res_celda = mayor ? RES_MAYOR : (menor ? RES_MENOR : RES_IGUAL);
    // A decision latched earlier in the scan always wins over later bits.
    assign res_fin   = dec_valida ? dec_q : res_celda;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            estado <= REPOSO;
        end else begin
            // NOTE: registers are updated with <= so every flop samples the pre-edge values.
            estado <= estado_sig;
        end
    end

    always_comb begin
        // NOTE: default assigned first so no path through the case leaves it unassigned (no latch).
        estado_sig = estado;
        case (estado)
            REPOSO:  if (start) estado_sig = COMPARA;
            COMPARA: if ((EARLY_EXIT && difiere) || ultimo) estado_sig = FIN;
            FIN:     estado_sig = REPOSO;
            default: estado_sig = REPOSO;
        endcase
    end

    // NOTE: the operand registers are reset too; they are few flops and keep
    // the cell inputs defined straight out of reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_q        <= '0;
            b_q        <= '0;
            signo_q    <= 1'b0;
            idx        <= '0;
            cnt        <= '0;
            dec_valida <= 1'b0;
            dec_q      <= RES_NINGUNO;
            res_q      <= RES_NINGUNO;
            ciclos_q   <= '0;
        end else begin
            case (estado)
                REPOSO: begin
                    if (start) begin
                        a_q        <= palabraA;
                        b_q        <= palabraB;
                        signo_q    <= signo;
                        idx        <= IW'(N - 1);
                        cnt        <= '0;
                        dec_valida <= 1'b0;
                        dec_q      <= RES_NINGUNO;
                        res_q      <= RES_NINGUNO;
                        ciclos_q   <= '0;
                    end
                end
                COMPARA: begin
                    cnt <= cnt + CW'(1);
                    idx <= idx - IW'(1);
                    if (difiere && !dec_valida) begin
                        dec_valida <= 1'b1;
                        dec_q      <= res_celda;
                    end
                    if (estado_sig == FIN) begin
                        res_q    <= res_fin;
                        ciclos_q <= cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign ocupado   = (estado != REPOSO);
    assign listo     = (estado == FIN);
    assign a_menor_b = (res_q == RES_MENOR);
    assign a_igual_b = (res_q == RES_IGUAL);
    assign a_mayor_b = (res_q == RES_MAYOR);
    assign ciclos    = ciclos_q;

endmodule
